// File: rtl/rv_mem_pkg.sv
// Shared encodings, FSM states and lane-mask helpers for the data memory port.
package rv_mem_pkg;

    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BEAT0,
        ST_BEAT1,
        ST_FIN
    } state_t;

    function automatic logic [2:0] size_bytes(input logic [1:0] sz);
        case (sz)
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // Byte mask over two consecutive words; bits [7:4] belong to the next word.
    function automatic logic [7:0] lane_mask(input logic [1:0] o, input logic [2:0] n);
        logic [7:0] m;
        m = (8'd1 << n) - 8'd1;
        return m << o;
    endfunction

    function automatic logic size_legal(input logic [2:0] sz, input logic store);
        if (store)
            return (sz == SZ_B) || (sz == SZ_H) || (sz == SZ_W);
        return (sz == SZ_B) || (sz == SZ_H) || (sz == SZ_W) || (sz == SZ_BU) || (sz == SZ_HU);
    endfunction

endpackage

// File: rtl/data_mem_port_if.sv
// Word-wide data memory bus between the load/store port (master) and memory (slave).
interface data_mem_port_if;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_rdata, mem_ack
    );

endinterface

// File: rtl/mem_lane_align.sv
// Combinational byte-lane alignment: store shift/enables and load extraction/extension.
module mem_lane_align
    import rv_mem_pkg::*;
(
    input  logic [1:0]  o,
    input  logic [2:0]  n,
    input  logic        sext,
    input  logic [31:0] wdata,
    input  logic [63:0] rword,
    output logic [7:0]  mask8,
    output logic [63:0] wshift,
    output logic [31:0] rext
);

    logic [5:0]  sh;
    logic [31:0] raw;

    always_comb begin
        sh     = {1'b0, o, 3'b000};
        mask8  = lane_mask(o, n);
        wshift = {32'b0, wdata} << sh;
        raw    = 32'(rword >> sh);
        case (n)
            3'd1:    rext = sext ? {{24{raw[7]}}, raw[7:0]}   : {24'b0, raw[7:0]};
            3'd2:    rext = sext ? {{16{raw[15]}}, raw[15:0]} : {16'b0, raw[15:0]};
            default: rext = raw;
        endcase
    end

endmodule

// File: rtl/data_mem_port.sv
// Load/store port: issues one or two word beats per access and returns extended load data.
module data_mem_port
    import rv_mem_pkg::*;
#(
    parameter int ALLOW_MISALIGN = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    MemRW,
    input  logic [2:0]              Size,
    input  logic [31:0]             addr,
    input  logic [31:0]             wdata,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic [31:0]             rdata,
    data_mem_port_if.master         bus
);

    state_t      state_q, state_n;

    logic        cmd_we_q, cmd_sext_q, cmd_cross_q;
    logic [1:0]  cmd_o_q;
    logic [2:0]  cmd_n_q;
    logic [7:0]  mask_q;
    logic [63:0] wshift_q;
    logic [31:0] lo_q;

    logic        idle;
    logic [1:0]  al_o;
    logic [2:0]  al_n;
    logic        al_sext;
    logic [63:0] al_rword;
    logic [7:0]  al_mask;
    logic [63:0] al_wshift;
    logic [31:0] al_rext;

    logic        latch, cross_in, legal;
    logic        busy_n, done_n, err_n, req_n, we_n;
    logic [31:0] rdata_n, addr_n, wd_n;
    logic [3:0]  be_n;

    // In IDLE the aligner works on the incoming command; afterwards on the latched one.
    assign idle     = (state_q == ST_IDLE);
    assign al_o     = idle ? addr[1:0] : cmd_o_q;
    assign al_n     = idle ? size_bytes(Size[1:0]) : cmd_n_q;
    assign al_sext  = idle ? 1'b0 : cmd_sext_q;
    assign al_rword = (state_q == ST_BEAT1) ? {bus.mem_rdata, lo_q} : {32'b0, bus.mem_rdata};

    mem_lane_align u_align (
        .o      (al_o),
        .n      (al_n),
        .sext   (al_sext),
        .wdata  (wdata),
        .rword  (al_rword),
        .mask8  (al_mask),
        .wshift (al_wshift),
        .rext   (al_rext)
    );

    assign cross_in = |al_mask[7:4];
    assign legal    = size_legal(Size, MemRW);

    always_comb begin
        state_n = state_q;
        latch   = 1'b0;
        busy_n  = busy;
        done_n  = 1'b0;
        err_n   = 1'b0;
        rdata_n = rdata;
        req_n   = bus.mem_req;
        we_n    = bus.mem_we;
        addr_n  = bus.mem_addr;
        be_n    = bus.mem_be;
        wd_n    = bus.mem_wdata;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    latch  = 1'b1;
                    busy_n = 1'b1;
                    if (!legal || (cross_in && ALLOW_MISALIGN == 0)) begin
                        state_n = ST_FIN;
                        done_n  = 1'b1;
                        err_n   = 1'b1;
                    end else begin
                        state_n = ST_BEAT0;
                        req_n   = 1'b1;
                        we_n    = MemRW;
                        addr_n  = {addr[31:2], 2'b00};
                        be_n    = MemRW ? al_mask[3:0] : 4'hF;
                        wd_n    = MemRW ? al_wshift[31:0] : 32'b0;
                    end
                end
            end
            ST_BEAT0: begin
                if (bus.mem_ack) begin
                    if (cmd_cross_q) begin
                        state_n = ST_BEAT1;
                        addr_n  = bus.mem_addr + 32'd4;
                        be_n    = cmd_we_q ? mask_q[7:4] : 4'hF;
                        wd_n    = cmd_we_q ? wshift_q[63:32] : 32'b0;
                    end else begin
                        state_n = ST_FIN;
                        req_n   = 1'b0;
                        done_n  = 1'b1;
                        if (!cmd_we_q)
                            rdata_n = al_rext;
                    end
                end
            end
            ST_BEAT1: begin
                if (bus.mem_ack) begin
                    state_n = ST_FIN;
                    req_n   = 1'b0;
                    done_n  = 1'b1;
                    if (!cmd_we_q)
                        rdata_n = al_rext;
                end
            end
            default: begin
                state_n = ST_IDLE;
                busy_n  = 1'b0;
                req_n   = 1'b0;
                we_n    = 1'b0;
                addr_n  = 32'b0;
                be_n    = 4'b0;
                wd_n    = 32'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
            rdata         <= 32'b0;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= 32'b0;
            bus.mem_be    <= 4'b0;
            bus.mem_wdata <= 32'b0;
        end else begin
            state_q       <= state_n;
            busy          <= busy_n;
            done          <= done_n;
            err           <= err_n;
            rdata         <= rdata_n;
            bus.mem_req   <= req_n;
            bus.mem_we    <= we_n;
            bus.mem_addr  <= addr_n;
            bus.mem_be    <= be_n;
            bus.mem_wdata <= wd_n;
        end
    end

    // Command and beat data need no reset: they are only read after being loaded.
    always_ff @(posedge clk) begin
        if (latch) begin
            cmd_we_q    <= MemRW;
            cmd_sext_q  <= (Size == SZ_B) || (Size == SZ_H);
            cmd_cross_q <= cross_in;
            cmd_o_q     <= addr[1:0];
            cmd_n_q     <= size_bytes(Size[1:0]);
            mask_q      <= al_mask;
            wshift_q    <= al_wshift;
        end
        if (state_q == ST_BEAT0 && bus.mem_ack)
            lo_q <= bus.mem_rdata;
    end

endmodule

// File: tb/tb_data_mem_port.sv
// Directed bench for data_mem_port: aligned/split loads and stores, errors, reset, ignored start.
module tb_data_mem_port;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, mem_rw;
    logic [2:0]  size;
    logic [31:0] addr, wdata;
    logic        busy, done, err;
    logic [31:0] rdata;

    logic        start0, mem_rw0;
    logic [2:0]  size0;
    logic [31:0] addr0, wdata0;
    logic        busy0, done0, err0;
    logic [31:0] rdata0;

    int checks = 0;
    int passes = 0;
    int fails  = 0;
    int ndone;

    data_mem_port_if bus1();
    data_mem_port_if bus0();

    always #5 clk = ~clk;

    data_mem_port #(.ALLOW_MISALIGN(1)) dut (
        .clk(clk), .rst(rst), .start(start), .MemRW(mem_rw), .Size(size),
        .addr(addr), .wdata(wdata), .busy(busy), .done(done), .err(err),
        .rdata(rdata), .bus(bus1)
    );

    data_mem_port #(.ALLOW_MISALIGN(0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .MemRW(mem_rw0), .Size(size0),
        .addr(addr0), .wdata(wdata0), .busy(busy0), .done(done0), .err(err0),
        .rdata(rdata0), .bus(bus0)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic rw, input logic [2:0] sz, input logic [31:0] a, input logic [31:0] d);
        start  = 1'b1;
        mem_rw = rw;
        size   = sz;
        addr   = a;
        wdata  = d;
        tick();
        start  = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        start = 0; mem_rw = 0; size = 0; addr = 0; wdata = 0;
        start0 = 0; mem_rw0 = 0; size0 = 0; addr0 = 0; wdata0 = 0;
        bus1.mem_ack = 0; bus1.mem_rdata = 0;
        bus0.mem_ack = 0; bus0.mem_rdata = 0;
        tick();
        tick();
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_done",  32'(done), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_req",   32'(bus1.mem_req), 32'd0);
        rst = 1'b0;
        tick();

        // SB 0x1003, zero-wait ack
        issue(1'b1, 3'b000, 32'h0000_1003, 32'h0000_00A5);
        chk("sb_req",   32'(bus1.mem_req), 32'd1);
        chk("sb_we",    32'(bus1.mem_we), 32'd1);
        chk("sb_addr",  bus1.mem_addr, 32'h0000_1000);
        chk("sb_be",    32'(bus1.mem_be), 32'h8);
        chk("sb_wdata", bus1.mem_wdata, 32'hA500_0000);
        chk("sb_busy",  32'(busy), 32'd1);
        bus1.mem_ack = 1;
        tick();
        bus1.mem_ack = 0;
        chk("sb_done", 32'(done), 32'd1);
        chk("sb_err",  32'(err), 32'd0);
        chk("sb_req_drop", 32'(bus1.mem_req), 32'd0);
        tick();
        chk("sb_done_pulse", 32'(done), 32'd0);
        chk("sb_busy_end",   32'(busy), 32'd0);

        // LH / LHU 0x2002
        issue(1'b0, 3'b001, 32'h0000_2002, 32'h0);
        chk("lh_be", 32'(bus1.mem_be), 32'hF);
        chk("lh_we", 32'(bus1.mem_we), 32'd0);
        bus1.mem_ack = 1; bus1.mem_rdata = 32'h80FF_1234;
        tick();
        bus1.mem_ack = 0;
        chk("lh_done",  32'(done), 32'd1);
        chk("lh_rdata", rdata, 32'hFFFF_80FF);
        tick();
        issue(1'b0, 3'b101, 32'h0000_2002, 32'h0);
        bus1.mem_ack = 1;
        tick();
        bus1.mem_ack = 0;
        chk("lhu_rdata", rdata, 32'h0000_80FF);
        tick();

        // LW 0x3003, split, one wait cycle per beat
        issue(1'b0, 3'b010, 32'h0000_3003, 32'h0);
        chk("lw_addr0", bus1.mem_addr, 32'h0000_3000);
        tick();
        chk("lw_req_wait", 32'(bus1.mem_req), 32'd1);
        bus1.mem_ack = 1; bus1.mem_rdata = 32'hDDCC_BBAA;
        tick();
        bus1.mem_ack = 0;
        chk("lw_addr1", bus1.mem_addr, 32'h0000_3004);
        chk("lw_req1",  32'(bus1.mem_req), 32'd1);
        tick();
        chk("lw_no_early_done", 32'(done), 32'd0);
        bus1.mem_ack = 1; bus1.mem_rdata = 32'h4433_2211;
        tick();
        bus1.mem_ack = 0;
        chk("lw_done",  32'(done), 32'd1);
        chk("lw_rdata", rdata, 32'h3322_11DD);
        tick();

        // SW 0xFFFFFFFE, split across address wrap
        issue(1'b1, 3'b010, 32'hFFFF_FFFE, 32'h1122_3344);
        chk("sw_addr0", bus1.mem_addr, 32'hFFFF_FFFC);
        chk("sw_be0",   32'(bus1.mem_be), 32'hC);
        chk("sw_wd0",   bus1.mem_wdata, 32'h3344_0000);
        bus1.mem_ack = 1;
        tick();
        chk("sw_addr1", bus1.mem_addr, 32'h0000_0000);
        chk("sw_be1",   32'(bus1.mem_be), 32'h3);
        chk("sw_wd1",   bus1.mem_wdata, 32'h0000_1122);
        tick();
        bus1.mem_ack = 0;
        chk("sw_done",  32'(done), 32'd1);
        chk("sw_rdata_kept", rdata, 32'h3322_11DD);
        tick();

        // Illegal sizes
        issue(1'b0, 3'b011, 32'h0000_0100, 32'h0);
        chk("ill_ld_done", 32'(done), 32'd1);
        chk("ill_ld_err",  32'(err), 32'd1);
        chk("ill_ld_req",  32'(bus1.mem_req), 32'd0);
        chk("ill_ld_rdata", rdata, 32'h3322_11DD);
        tick();
        chk("ill_ld_err_clr", 32'(err), 32'd0);
        issue(1'b1, 3'b100, 32'h0000_0100, 32'h55);
        chk("ill_st_done", 32'(done), 32'd1);
        chk("ill_st_err",  32'(err), 32'd1);
        chk("ill_st_req",  32'(bus1.mem_req), 32'd0);
        tick();

        // Misaligned word with splitting disabled
        start0 = 1; mem_rw0 = 0; size0 = 3'b010; addr0 = 32'h2;
        tick();
        start0 = 0;
        chk("mis0_done", 32'(done0), 32'd1);
        chk("mis0_err",  32'(err0), 32'd1);
        chk("mis0_req",  32'(bus0.mem_req), 32'd0);
        chk("mis0_rdata", rdata0, 32'd0);
        tick();

        // Reset while BEAT1 is requesting
        issue(1'b0, 3'b010, 32'h0000_3003, 32'h0);
        bus1.mem_ack = 1; bus1.mem_rdata = 32'h1;
        tick();
        bus1.mem_ack = 0;
        chk("rstmid_req_before", 32'(bus1.mem_req), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rstmid_req",   32'(bus1.mem_req), 32'd0);
        chk("rstmid_busy",  32'(busy), 32'd0);
        chk("rstmid_rdata", rdata, 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // start held during busy is ignored
        ndone = 0;
        issue(1'b0, 3'b010, 32'h0000_4000, 32'h0);
        start = 1'b1;
        tick();
        ndone += int'(done);
        bus1.mem_ack = 1; bus1.mem_rdata = 32'h1234_5678;
        tick();
        bus1.mem_ack = 0;
        start = 1'b0;
        chk("ign_done_cycle", 32'(done), 32'd1);
        chk("ign_rdata", rdata, 32'h1234_5678);
        for (int i = 0; i < 6; i++) begin
            ndone += int'(done);
            tick();
        end
        chk("ign_one_done", 32'(ndone), 32'd1);
        chk("ign_idle_req", 32'(bus1.mem_req), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
